// File: rtl/reg_bank_controller.sv
// Command-side master for a bank of 16-bit E/FunSel/I/Q registers: load, clear, inc/dec xK, read-back.
// Optional macro CMD_SATURATE_EN: stop inc at 0xFFFF / dec at 0x0000 instead of letting the register wrap.
module reg_bank_controller #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     CmdValid,
    output logic                     CmdReady,
    input  logic [1:0]               CmdOp,
    input  logic [3:0]               CmdSel,
    input  logic [15:0]              CmdData,
    input  logic [CNT_W-1:0]         CmdCount,
    output logic [NUM_REGS-1:0]      RegE,
    output logic [1:0]               RegFunSel,
    output logic [15:0]              RegI,
    input  logic [16*NUM_REGS-1:0]   RegQ,
    output logic                     RspValid,
    input  logic                     RspReady,
    output logic [15:0]              RspData,
    output logic                     RspErr,
    output logic                     RspSat
);
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel_r;
    logic [CNT_W-1:0]   remaining;
    logic               err_r;
    logic               sat_r;
    logic [DATA_W-1:0]  sel_q_c;
    logic               cmd_err_c;
    logic               sat_start_c;
    logic               sat_issue_c;

    // Read-back mux for the latched target register
    always_comb begin
        sel_q_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (sel_r == SEL_W'(i)) sel_q_c = RegQ[DATA_W*i +: DATA_W];
        end
    end

    assign cmd_err_c = (32'(CmdSel) >= NUM_REGS);

`ifdef CMD_SATURATE_EN
    logic [1:0]        op_r;
    logic [DATA_W-1:0] cmd_q_c;

    always_comb begin
        cmd_q_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (CmdSel == SEL_W'(i)) cmd_q_c = RegQ[DATA_W*i +: DATA_W];
        end
    end

    // RegE is registered, so during an issue cycle RegQ is the pre-issue value:
    // the next issue would overshoot when this one lands exactly on the limit.
    always_comb begin
        sat_start_c = ((CmdOp == 2'b01) && (cmd_q_c == 16'hFFFF)) ||
                      ((CmdOp == 2'b00) && (cmd_q_c == 16'h0000));
        sat_issue_c = ((op_r == 2'b01) && (sel_q_c == 16'hFFFE)) ||
                      ((op_r == 2'b00) && (sel_q_c == 16'h0001));
    end
`else
    assign sat_start_c = 1'b0;
    assign sat_issue_c = 1'b0;
`endif

    // Command FSM; all outputs registered
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            CmdReady  <= 1'b0;
            RegE      <= '0;
            RegFunSel <= 2'b00;
            RegI      <= '0;
            RspValid  <= 1'b0;
            RspData   <= '0;
            RspErr    <= 1'b0;
            RspSat    <= 1'b0;
            sel_r     <= '0;
            remaining <= '0;
            err_r     <= 1'b0;
            sat_r     <= 1'b0;
`ifdef CMD_SATURATE_EN
            op_r      <= 2'b00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    CmdReady <= 1'b1;
                    if (CmdValid && CmdReady) begin
                        CmdReady <= 1'b0;
                        sel_r    <= CmdSel;
                        err_r    <= cmd_err_c;
                        sat_r    <= 1'b0;
`ifdef CMD_SATURATE_EN
                        op_r     <= CmdOp;
`endif
                        if (cmd_err_c || (!CmdOp[1] && (CmdCount == '0))) begin
                            state <= CAPTURE;
                        end else if (sat_start_c) begin
                            sat_r <= 1'b1;
                            state <= CAPTURE;
                        end else begin
                            state     <= ISSUE;
                            RegE      <= NUM_REGS'(1) << CmdSel;
                            RegFunSel <= CmdOp;
                            RegI      <= (CmdOp == 2'b10) ? CmdData : 16'h0000;
                            remaining <= CmdOp[1] ? CNT_W'(1) : CmdCount;
                        end
                    end
                end
                ISSUE: begin
                    if ((remaining == CNT_W'(1)) || sat_issue_c) begin
                        sat_r     <= sat_issue_c && (remaining != CNT_W'(1));
                        state     <= CAPTURE;
                        RegE      <= '0;
                        RegFunSel <= 2'b00;
                        RegI      <= '0;
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    RspData  <= err_r ? 16'h0000 : sel_q_c;
                    RspErr   <= err_r;
                    RspSat   <= sat_r;
                    RspValid <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        CmdReady <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_controller.sv
// Bench for reg_bank_controller: behavioural register bank plus a per-command arithmetic reference model.
module tb_reg_bank_controller;
    localparam int unsigned NR = 4;
    localparam int unsigned CW = 8;
`ifdef CMD_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic            Clock = 1'b0;
    logic            Reset = 1'b0;
    logic            CmdValid = 1'b0;
    logic            CmdReady;
    logic [1:0]      CmdOp = 2'b00;
    logic [3:0]      CmdSel = 4'd0;
    logic [15:0]     CmdData = 16'h0;
    logic [CW-1:0]   CmdCount = '0;
    logic [NR-1:0]   RegE;
    logic [1:0]      RegFunSel;
    logic [15:0]     RegI;
    logic [16*NR-1:0] RegQ;
    logic            RspValid;
    logic            RspReady = 1'b0;
    logic [15:0]     RspData;
    logic            RspErr;
    logic            RspSat;

    reg_bank_controller #(.NUM_REGS(NR), .CNT_W(CW)) dut (
        .Clock(Clock), .Reset(Reset),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp), .CmdSel(CmdSel),
        .CmdData(CmdData), .CmdCount(CmdCount),
        .RegE(RegE), .RegFunSel(RegFunSel), .RegI(RegI), .RegQ(RegQ),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
        .RspErr(RspErr), .RspSat(RspSat)
    );

    always #5 Clock = ~Clock;

    // Attached register bank (not reset by the controller)
    logic [15:0] bank [NR] = '{default: 16'h0};
    always @(posedge Clock) begin
        for (int i = 0; i < NR; i++) begin
            if (RegE[i]) begin
                case (RegFunSel)
                    2'b00: bank[i] <= bank[i] - 16'd1;
                    2'b01: bank[i] <= bank[i] + 16'd1;
                    2'b10: bank[i] <= RegI;
                    default: bank[i] <= 16'h0;
                endcase
            end
        end
    end

    always_comb begin
        RegQ = '0;
        for (int i = 0; i < NR; i++) RegQ[16*i +: 16] = bank[i];
    end

    // E-cycle monitor: counts pulses and flags any pulse that is not the expected one-hot/op/data
    int            e_cnt = 0;
    logic          e_bad = 1'b0;
    logic [NR-1:0] exp_e = '0;
    logic [1:0]    exp_fs = 2'b00;
    logic [15:0]   exp_i = 16'h0;
    always @(posedge Clock) begin
        if (RegE != '0) begin
            e_cnt = e_cnt + 1;
            if ((RegE != exp_e) || (RegFunSel != exp_fs) || (RegI != exp_i)) e_bad = 1'b1;
        end
    end

    int n_pass = 0;
    int n_total = 0;
    logic [15:0] model [NR] = '{default: 16'h0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_cmd(input logic [1:0] op, input int sel, input logic [15:0] data,
                           input int count, input int hold);
        logic [15:0] v;
        int          pulses;
        logic        sat;
        logic        err;
        int          n;
        logic        busy_bad;

        err    = (sel >= NR);
        sat    = 1'b0;
        pulses = 0;
        v      = 16'h0;
        if (!err) begin
            v = model[sel];
            case (op)
                2'b10: begin v = data; pulses = 1; end
                2'b11: begin v = 16'h0; pulses = 1; end
                2'b01: begin
                    if (SAT_EN && (count > (65535 - int'(v)))) begin
                        pulses = 65535 - int'(v); v = 16'hFFFF; sat = 1'b1;
                    end else begin
                        pulses = count; v = v + 16'(count);
                    end
                end
                default: begin
                    if (SAT_EN && (count > int'(v))) begin
                        pulses = int'(v); v = 16'h0; sat = 1'b1;
                    end else begin
                        pulses = count; v = v - 16'(count);
                    end
                end
            endcase
            model[sel] = v;
        end

        @(negedge Clock);
        CmdValid = 1'b1; CmdOp = op; CmdSel = 4'(sel); CmdData = data; CmdCount = CW'(count);
        e_cnt = 0; e_bad = 1'b0;
        exp_e  = err ? '0 : (NR'(1) << sel);
        exp_fs = op;
        exp_i  = (op == 2'b10) ? data : 16'h0;
        n = 0;
        while (!CmdReady && n < 20) begin @(negedge Clock); n++; end
        check("cmd_ready_idle", 32'(CmdReady), 32'd1);
        @(posedge Clock); #1;
        CmdValid = 1'b0;

        n = 0; busy_bad = 1'b0;
        while (!RspValid && n < 300) begin
            if (CmdReady) busy_bad = 1'b1;
            @(posedge Clock); #1;
            n++;
        end
        check("latency_edges", 32'(n), 32'(pulses + 1));
        check("busy_not_ready", 32'(busy_bad | CmdReady), 32'd0);
        check("e_pulses", 32'(e_cnt), 32'(pulses));
        check("e_onehot_op", 32'(e_bad), 32'd0);
        check("rsp_data", 32'(RspData), 32'(v));
        check("rsp_err", 32'(RspErr), 32'(err));
        check("rsp_sat", 32'(RspSat), 32'(sat));

        // Hold response; a second command is presented and must not be taken
        for (int h = 0; h < hold; h++) begin
            CmdValid = 1'b1; CmdOp = 2'b11; CmdSel = 4'd0;
            @(posedge Clock); #1;
            check("hold_valid", 32'(RspValid), 32'd1);
            check("hold_data", 32'(RspData), 32'(v));
            check("hold_cmd_ready", 32'(CmdReady), 32'd0);
        end
        RspReady = 1'b1;
        @(posedge Clock); #1;
        RspReady = 1'b0;
        CmdValid = 1'b0;
        check("rsp_valid_drop", 32'(RspValid), 32'd0);
        check("cmd_ready_back", 32'(CmdReady), 32'd1);
        check("no_extra_e", 32'(e_cnt), 32'(pulses));
    endtask

    initial begin
        #1;
        check("rst_cmd_ready", 32'(CmdReady), 32'd0);
        check("rst_rege", 32'(RegE), 32'd0);
        check("rst_funsel", 32'(RegFunSel), 32'd0);
        check("rst_regi", 32'(RegI), 32'd0);
        check("rst_rsp", {13'd0, RspValid, RspErr, RspSat, RspData}, 32'd0);
        @(negedge Clock); @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check("post_rst_ready", 32'(CmdReady), 32'd1);

        // Directed cases
        run_cmd(2'b10, 2, 16'h1234, 0, 0);
        run_cmd(2'b10, 1, 16'h00FE, 0, 0);
        run_cmd(2'b01, 1, 16'h0, 3, 0);
        run_cmd(2'b10, 1, 16'hFFFE, 0, 0);
        run_cmd(2'b01, 1, 16'h0, 3, 1);
        run_cmd(2'b11, 0, 16'h5555, 0, 0);
        run_cmd(2'b00, 0, 16'h0, 1, 0);
        run_cmd(2'b10, 3, 16'hBEEF, 0, 0);
        run_cmd(2'b01, 3, 16'h0, 0, 0);
        run_cmd(2'b10, 7, 16'hAAAA, 0, 2);
        run_cmd(2'b00, 2, 16'h0, 2, 5);

        // Randomised commands, biased toward limit values and short counts
        for (int k = 0; k < 40; k++) begin
            logic [15:0] d;
            int          c;
            case ($urandom_range(0, 4))
                0: d = 16'hFFFE;
                1: d = 16'h0001;
                2: d = 16'hFFFF;
                3: d = 16'h0000;
                default: d = 16'($urandom);
            endcase
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
            run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 5)), d, c, int'($urandom_range(0, 3)));
        end

        // Reset during the third of ten increments on reg 0 starting from zero
        run_cmd(2'b11, 0, 16'h0, 0, 0);
        @(negedge Clock);
        CmdValid = 1'b1; CmdOp = 2'b01; CmdSel = 4'd0; CmdCount = CW'(10);
        @(posedge Clock); #1;
        CmdValid = 1'b0;
        @(posedge Clock); @(posedge Clock); #2;
        check("third_issue_e", 32'(RegE), 32'd1);
        Reset = 1'b0;
        #1;
        check("rst_mid_rege", 32'(RegE), 32'd0);
        check("rst_mid_valid", 32'(RspValid), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_mid_no_rsp", 32'(RspValid), 32'd0);
        check("rst_mid_ready", 32'(CmdReady), 32'd1);
        model[0] = 16'd2;
        run_cmd(2'b01, 0, 16'h0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
